// File: rtl/frame_downscaler_if.sv
// frame_downscaler_if: pixel input, frame-buffer write and status signals.
// master drives pixels and vsync; slave is the downscaler.
interface frame_downscaler_if;
   logic        in_wren;
   logic [9:0]  in_x;
   logic [9:0]  in_y;
   logic [8:0]  in_rgb;
   logic        cam_vsync;
   logic        out_we;
   logic [16:0] out_addr;
   logic [8:0]  out_data;
   logic        frame_done;
   logic [16:0] pix_count;

   modport master (
      output in_wren, in_x, in_y, in_rgb, cam_vsync,
      input  out_we, out_addr, out_data, frame_done, pix_count
   );

   modport slave (
      input  in_wren, in_x, in_y, in_rgb, cam_vsync,
      output out_we, out_addr, out_data, frame_done, pix_count
   );
endinterface

// File: rtl/frame_downscaler.sv
// frame_downscaler: 2x2 box average, 640x480 -> 320x240, 3 bits per channel.
// Pixels pair horizontally; even-row pair sums wait in a line buffer.
module frame_downscaler #(
   parameter int SRC_W = 640,
   parameter int SRC_H = 480
) (
   input logic               pclk,
   input logic               reset,
   frame_downscaler_if.slave bus
);
   localparam int          DST_W   = SRC_W / 2;
   localparam int          DST_H   = SRC_H / 2;
   localparam logic [9:0]  X_LIM   = 10'(SRC_W);
   localparam logic [9:0]  Y_LIM   = 10'(SRC_H);
   localparam logic [16:0] PITCH   = 17'(DST_W);
   localparam logic [16:0] CNT_MAX = 17'(DST_W * DST_H);

   typedef enum logic [1:0] {
      WAIT_FRAME,
      ACTIVE,
      FLUSH
   } state_e;

   state_e state_q, state_d;
   logic   flush;

   logic        vsync_q;
   logic [11:0] hsum_q;
   logic        pair_valid_q;
   logic [8:0]  pair_col_q;
   logic [9:0]  pair_row_q;
   logic [9:0]  even_row_q;
   logic        even_row_valid_q;
   logic [11:0] rd_q;
   logic        out_we_q;
   logic [16:0] out_addr_q;
   logic [8:0]  out_data_q;
   logic [16:0] pix_count_q;

   logic [11:0] lb_mem [DST_W];

   logic        accept, odd_x, odd_y;
   logic        pair_ok, store, rd_en, emit;
   logic [8:0]  col, row;
   logic [11:0] pair_sum;
   logic [4:0]  tot_r, tot_g, tot_b;
   logic [16:0] addr;

   always_comb begin
      state_d = state_q;
      flush   = 1'b0;
      unique case (state_q)
         WAIT_FRAME: if (!bus.cam_vsync) state_d = ACTIVE;
         ACTIVE:     if (bus.cam_vsync && !vsync_q) state_d = FLUSH;
         FLUSH: begin
            flush   = 1'b1;
            state_d = WAIT_FRAME;
         end
         default:    state_d = WAIT_FRAME;
      endcase
   end

   always_comb begin
      accept = (state_q == ACTIVE) && bus.in_wren &&
               (bus.in_x < X_LIM) && (bus.in_y < Y_LIM);
      odd_x  = bus.in_x[0];
      odd_y  = bus.in_y[0];
      col    = bus.in_x[9:1];
      row    = bus.in_y[9:1];
      pair_sum = {hsum_q[11:8] + {1'b0, bus.in_rgb[8:6]},
                  hsum_q[7:4]  + {1'b0, bus.in_rgb[5:3]},
                  hsum_q[3:0]  + {1'b0, bus.in_rgb[2:0]}};
      // a pair only completes against its own even-x partner on the same row
      pair_ok = accept && odd_x && pair_valid_q &&
                (pair_col_q == col) && (pair_row_q == bus.in_y);
      store  = pair_ok && !odd_y;
      rd_en  = accept && !odd_x && odd_y;
      emit   = pair_ok && odd_y && even_row_valid_q &&
               (even_row_q == bus.in_y - 10'd1);
      tot_r  = {1'b0, pair_sum[11:8]} + {1'b0, rd_q[11:8]};
      tot_g  = {1'b0, pair_sum[7:4]}  + {1'b0, rd_q[7:4]};
      tot_b  = {1'b0, pair_sum[3:0]}  + {1'b0, rd_q[3:0]};
      addr   = 17'(row) * PITCH + 17'(col);
   end

   always_ff @(posedge pclk) begin
      if (store) lb_mem[col] <= pair_sum;
      if (rd_en) rd_q <= lb_mem[col];
   end

   always_ff @(posedge pclk) begin
      if (reset) begin
         state_q          <= WAIT_FRAME;
         vsync_q          <= 1'b0;
         hsum_q           <= '0;
         pair_valid_q     <= 1'b0;
         pair_col_q       <= '0;
         pair_row_q       <= '0;
         even_row_q       <= '0;
         even_row_valid_q <= 1'b0;
         out_we_q         <= 1'b0;
         out_addr_q       <= '0;
         out_data_q       <= '0;
         pix_count_q      <= '0;
      end else begin
         state_q  <= state_d;
         vsync_q  <= bus.cam_vsync;
         out_we_q <= emit;
         if (accept && !odd_x) begin
            hsum_q       <= {1'b0, bus.in_rgb[8:6],
                             1'b0, bus.in_rgb[5:3],
                             1'b0, bus.in_rgb[2:0]};
            pair_valid_q <= 1'b1;
            pair_col_q   <= col;
            pair_row_q   <= bus.in_y;
         end else if (accept) begin
            pair_valid_q <= 1'b0;
         end
         if (store) begin
            even_row_q       <= bus.in_y;
            even_row_valid_q <= 1'b1;
         end
         if (emit) begin
            out_addr_q <= addr;
            out_data_q <= {tot_r[4:2], tot_g[4:2], tot_b[4:2]};
            if (pix_count_q != CNT_MAX) pix_count_q <= pix_count_q + 17'd1;
         end
         if (flush) begin
            pix_count_q      <= '0;
            pair_valid_q     <= 1'b0;
            even_row_valid_q <= 1'b0;
         end
      end
   end

   assign bus.out_we     = out_we_q;
   assign bus.out_addr   = out_addr_q;
   assign bus.out_data   = out_data_q;
   assign bus.frame_done = flush;
   assign bus.pix_count  = pix_count_q;
endmodule

// File: tb/tb_frame_downscaler.sv
// tb_frame_downscaler: directed vectors against a pixel-level average model.
// Literal checks pin the model at the block boundaries.
module tb_frame_downscaler;
   logic pclk;
   logic reset;
   frame_downscaler_if bus ();

   frame_downscaler #(.SRC_W(640), .SRC_H(480)) dut (
      .pclk  (pclk),
      .reset (reset),
      .bus   (bus)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   int vectors = 0;
   int miscmp  = 0;
   bit chk_en  = 0;
   int wr_cnt  = 0;
   int last_addr = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscmp++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // model state: what the frame buffer must see, from the averaging rules
   logic [11:0] m_line [320];
   int          m_phase = 0;
   bit          m_pv = 0;
   int          m_px, m_py;
   logic [8:0]  m_prgb;
   bit          m_evv = 0;
   int          m_evrow = 0;
   bit          m_vs_prev = 0;
   bit          exp_we = 0;
   int          exp_addr = 0;
   logic [8:0]  exp_data = '0;
   int          exp_cnt = 0;
   bit          exp_done = 0;

   always @(posedge pclk) begin : model
      int x, y, r, g, b;
      bit acc;
      if (reset) begin
         m_phase = 0; m_pv = 0; m_evv = 0; m_vs_prev = 0;
         exp_we = 0; exp_addr = 0; exp_data = '0; exp_cnt = 0;
      end else begin
         exp_we = 0;
         x = int'(bus.in_x);
         y = int'(bus.in_y);
         acc = (m_phase == 1) && bus.in_wren && x < 640 && y < 480;
         if (acc && x % 2 == 0) begin
            m_pv = 1; m_px = x; m_py = y; m_prgb = bus.in_rgb;
         end else if (acc) begin
            if (m_pv && m_px == x - 1 && m_py == y) begin
               r = int'(m_prgb[8:6]) + int'(bus.in_rgb[8:6]);
               g = int'(m_prgb[5:3]) + int'(bus.in_rgb[5:3]);
               b = int'(m_prgb[2:0]) + int'(bus.in_rgb[2:0]);
               if (y % 2 == 0) begin
                  m_line[x/2] = {4'(r), 4'(g), 4'(b)};
                  m_evrow = y; m_evv = 1;
               end else if (m_evv && m_evrow == y - 1) begin
                  r += int'(m_line[x/2][11:8]);
                  g += int'(m_line[x/2][7:4]);
                  b += int'(m_line[x/2][3:0]);
                  exp_we = 1;
                  exp_addr = (y / 2) * 320 + x / 2;
                  exp_data = {3'(r / 4), 3'(g / 4), 3'(b / 4)};
                  if (exp_cnt < 76800) exp_cnt++;
               end
            end
            m_pv = 0;
         end
         if (m_phase == 2) begin
            exp_cnt = 0; m_pv = 0; m_evv = 0; m_phase = 0;
         end else if (m_phase == 0) begin
            if (!bus.cam_vsync) m_phase = 1;
         end else if (bus.cam_vsync && !m_vs_prev) begin
            m_phase = 2;
         end
         m_vs_prev = bus.cam_vsync;
      end
      exp_done = (m_phase == 2);
   end

   always @(negedge pclk) begin
      if (chk_en) begin
         chk("out_we", 32'(bus.out_we), 32'(exp_we));
         chk("out_addr", 32'(bus.out_addr), 32'(exp_addr));
         chk("out_data", 32'(bus.out_data), 32'(exp_data));
         chk("frame_done", 32'(bus.frame_done), 32'(exp_done));
         chk("pix_count", 32'(bus.pix_count), 32'(exp_cnt));
         if (bus.out_we) begin
            wr_cnt++;
            last_addr = int'(bus.out_addr);
         end
      end
   end

   function automatic logic [8:0] pat_rgb(input int x, input int y);
      return 9'((x * 37 + y * 101 + 5) % 512);
   endfunction

   task automatic px(input int x, input int y, input logic [8:0] rgb);
      bus.in_wren = 1'b1;
      bus.in_x    = 10'(x);
      bus.in_y    = 10'(y);
      bus.in_rgb  = rgb;
      @(posedge pclk); #1;
      bus.in_wren = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge pclk); #1; end
   endtask

   task automatic line(input int y, input int x0, input int x1, input bit pat);
      for (int x = x0; x <= x1; x++)
         px(x, y, pat ? pat_rgb(x, y) : 9'h1FF);
   endtask

   int w0;

   initial begin
      reset = 1'b1;
      bus.cam_vsync = 1'b0;
      bus.in_wren = 1'b0;
      bus.in_x = '0;
      bus.in_y = '0;
      bus.in_rgb = '0;
      idle(2);
      chk_en = 1;
      px(0, 0, 9'h1FF); px(1, 0, 9'h1FF);
      px(0, 1, 9'h1FF); px(1, 1, 9'h1FF);
      chk("rst_we", 32'(bus.out_we), 0);
      chk("rst_addr", 32'(bus.out_addr), 0);
      chk("rst_data", 32'(bus.out_data), 0);
      chk("rst_done", 32'(bus.frame_done), 0);
      chk("rst_cnt", 32'(bus.pix_count), 0);

      bus.cam_vsync = 1'b1;
      reset = 1'b0;
      idle(2);
      w0 = wr_cnt;
      px(0, 0, 9'h1FF); px(1, 0, 9'h1FF);
      px(0, 1, 9'h1FF); px(1, 1, 9'h1FF);
      idle(2);
      chk("wait_ignored", 32'(wr_cnt - w0), 0);

      bus.cam_vsync = 1'b0;
      idle(2);
      px(0, 0, 9'h1C0); px(1, 0, 9'h1C0);
      px(0, 1, 9'h180); px(1, 1, 9'h140);
      chk("blk_we", 32'(bus.out_we), 1);
      chk("blk_addr", 32'(bus.out_addr), 0);
      chk("blk_data", 32'(bus.out_data), 32'h180);
      idle(1);
      chk("blk_we_off", 32'(bus.out_we), 0);
      chk("blk_hold", 32'(bus.out_data), 32'h180);

      w0 = wr_cnt;
      line(3, 0, 15, 1);
      idle(2);
      chk("row3_no_row2", 32'(wr_cnt - w0), 0);

      w0 = wr_cnt;
      line(0, 0, 639, 0);
      line(1, 0, 639, 0);
      idle(2);
      chk("row1_writes", 32'(wr_cnt - w0), 320);
      chk("row1_last", 32'(last_addr), 319);
      chk("row1_cnt", 32'(bus.pix_count), 321);

      w0 = wr_cnt;
      px(640, 1, 9'h1FF); px(641, 1, 9'h1FF);
      px(0, 480, 9'h1FF); px(1, 480, 9'h1FF);
      px(7, 1, 9'h1FF);
      px(10, 2, 9'h1FF); px(11, 3, 9'h1FF);
      idle(2);
      chk("oob_lone_writes", 32'(wr_cnt - w0), 0);
      chk("oob_lone_cnt", 32'(bus.pix_count), 321);

      line(478, 0, 639, 0);
      line(479, 0, 638, 0);
      bus.cam_vsync = 1'b1;
      px(639, 479, 9'h1FF);
      chk("eof_we", 32'(bus.out_we), 1);
      chk("eof_addr", 32'(bus.out_addr), 76799);
      chk("eof_data", 32'(bus.out_data), 32'h1FF);
      chk("eof_done", 32'(bus.frame_done), 1);
      chk("eof_cnt", 32'(bus.pix_count), 641);
      idle(1);
      chk("eof_done_off", 32'(bus.frame_done), 0);
      chk("eof_cnt_clr", 32'(bus.pix_count), 0);

      idle(3);
      bus.cam_vsync = 1'b0;
      idle(2);
      line(0, 0, 7, 1);
      px(0, 1, pat_rgb(0, 1)); px(1, 1, pat_rgb(1, 1));
      px(2, 1, pat_rgb(2, 1));
      reset = 1'b1;
      px(3, 1, pat_rgb(3, 1));
      chk("mid_rst_we", 32'(bus.out_we), 0);
      chk("mid_rst_addr", 32'(bus.out_addr), 0);
      chk("mid_rst_data", 32'(bus.out_data), 0);
      chk("mid_rst_cnt", 32'(bus.pix_count), 0);
      reset = 1'b0;
      idle(2);
      w0 = wr_cnt;
      line(0, 0, 15, 1);
      line(1, 0, 15, 1);
      idle(2);
      chk("new_frame_writes", 32'(wr_cnt - w0), 8);
      chk("new_frame_cnt", 32'(bus.pix_count), 8);

      chk_en = 0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
      $finish;
   end
endmodule
